key_schedule_gen: RTL and testbench

Parametrised round-key byte generator. It is the successor to the fixed three-output decrypt scheduler.
- Emits LANES round-key bytes per cycle, in either ascending (encrypt) or descending (decrypt) order.
- Takes a loadable 128-bit key; each run is framed by a start/done handshake; the output side has a valid/ready handshake.
- Feeds the round datapath of the encrypt/decrypt cores.

---
 rtl/key_sched_pkg.sv | 27 ++
 rtl/key_sched_lane.sv | 20 ++
 rtl/key_schedule_gen.sv | 171 +++++++++++++++++
 tb/tb_key_schedule_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_sched_pkg.sv
// Shared constants, FSM encoding and the round-key byte function used by the
// round-key byte generator and its lane slices.
package key_sched_pkg;

  localparam int KEY_BYTES = 16;
  localparam int IDX_W     = 8;
  localparam logic [127:0] KEY_RESET = {128{1'b1}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // K(n) = n XOR kb[((n mod 16) - 1) mod 16], kb[0] being the key's top byte.
  // The 4-bit subtraction wraps n mod 16 == 0 onto kb[15].
  function automatic logic [7:0] key_byte(input logic [127:0] key,
                                          input logic [IDX_W-1:0] idx);
    logic [3:0] sel;
    logic [3:0] pos_from_lsb;
    logic [7:0] kb;
    sel          = idx[3:0] - 4'd1;
    pos_from_lsb = 4'd15 - sel;
    kb           = 8'(key >> {pos_from_lsb, 3'b000});
    return idx ^ kb;
  endfunction

endpackage

// File: rtl/key_sched_lane.sv
// One output lane: the round-key byte for a given index, forced to zero when
// the lane falls outside the run's index range.
module key_sched_lane
  import key_sched_pkg::*;
(
  input  logic [127:0]     key_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             vld_i,
  output logic [7:0]       byte_o
);

  // Masked lanes carry 0x00 so the consumer never sees stale key material.
  always_comb begin
    byte_o = 8'h00;
    if (vld_i) begin
      byte_o = key_byte(key_i, idx_i);
    end
  end

endmodule

// File: rtl/key_schedule_gen.sv
// Round-key byte generator: emits LANES key bytes per beat in ascending or
// descending index order, framed by start/done with a valid/ready output.
module key_schedule_gen
  import key_sched_pkg::*;
#(
  parameter int LANES    = 3,
  parameter int NUM_KEYS = 96
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [127:0]       key_in,
  input  logic               key_load,
  input  logic               start,
  input  logic               decrypt,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [8*LANES-1:0] out_keys,
  output logic [7:0]         out_idx,
  output logic [LANES-1:0]   out_lane_mask,
  output logic               busy,
  output logic               done
);

  // Two extra bits keep the descending final beat (index below 1) and the
  // ascending overshoot (index above NUM_KEYS) unambiguous in signed compares.
  localparam int IW = IDX_W + 2;
  localparam logic signed [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic signed [IW-1:0] IDX_STEP = IW'(LANES);
  localparam logic signed [IW-1:0] IDX_LAST = IW'(NUM_KEYS);
  localparam logic signed [IW-1:0] IDX_TOP  = IW'(NUM_KEYS - LANES + 1);

  state_e                state_q, state_d;
  logic [127:0]          key_q, key_d;
  logic                  dec_q, dec_d;
  logic signed [IW-1:0]  idx_q, idx_d;
  logic                  vld_q, vld_d;
  logic [8*LANES-1:0]    keys_q, keys_d;
  logic [7:0]            oidx_q, oidx_d;
  logic [LANES-1:0]      mask_q, mask_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [127:0]          eff_key;
  logic signed [IW-1:0]  beat_idx;
  logic                  fire;
  logic                  last_beat;
  logic [LANES-1:0]      lane_vld;
  logic [8*LANES-1:0]    lane_bytes;

  assign fire      = (state_q == ST_RUN) && vld_q && out_ready;
  assign last_beat = dec_q ? (idx_q <= IDX_ONE) : ((idx_q + IDX_STEP) > IDX_LAST);

  // A key loaded on the start edge must already feed the first beat.
  assign eff_key = ((state_q == ST_IDLE) && key_load) ? key_in : key_q;

  // Lane-0 index of the beat that would be registered on this edge.
  always_comb begin
    beat_idx = idx_q;
    if (state_q == ST_IDLE) begin
      beat_idx = decrypt ? IDX_TOP : IDX_ONE;
    end else begin
      beat_idx = dec_q ? (idx_q - IDX_STEP) : (idx_q + IDX_STEP);
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic signed [IW-1:0] lane_idx;
    assign lane_idx    = beat_idx + IW'(j);
    assign lane_vld[j] = (lane_idx >= IDX_ONE) && (lane_idx <= IDX_LAST);
    key_sched_lane u_lane (
      .key_i  (eff_key),
      .idx_i  (lane_idx[IDX_W-1:0]),
      .vld_i  (lane_vld[j]),
      .byte_o (lane_bytes[8*j +: 8])
    );
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: a run ends only when its final beat is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (fire && last_beat) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: next values for the key, index and beat registers.
  always_comb begin
    key_d  = key_q;
    dec_d  = dec_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    keys_d = keys_q;
    oidx_d = oidx_q;
    mask_d = mask_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_load) key_d = key_in;
        if (start) begin
          dec_d  = decrypt;
          idx_d  = beat_idx;
          vld_d  = 1'b1;
          keys_d = lane_bytes;
          oidx_d = beat_idx[IDX_W-1:0];
          mask_d = lane_vld;
          busy_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (last_beat) begin
            vld_d  = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            idx_d  = beat_idx;
            keys_d = lane_bytes;
            oidx_d = beat_idx[IDX_W-1:0];
            mask_d = lane_vld;
          end
        end
      end
      default: ;
    endcase
  end

  // Key, index and output-beat registers; reset also aborts any run.
  always_ff @(posedge CLK) begin
    if (RST) begin
      key_q  <= KEY_RESET;
      dec_q  <= 1'b0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      keys_q <= '0;
      oidx_q <= '0;
      mask_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      key_q  <= key_d;
      dec_q  <= dec_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      keys_q <= keys_d;
      oidx_q <= oidx_d;
      mask_q <= mask_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign out_valid     = vld_q;
  assign out_keys      = keys_q;
  assign out_idx       = oidx_q;
  assign out_lane_mask = mask_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_key_schedule_gen.sv
// Scoreboard bench for key_schedule_gen: three instances (3/96, 3/16, 4/10).
module tb_key_schedule_gen;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] keys;
    logic [3:0]  mask;
  } beat_t;

  localparam logic [127:0] KEY_ONES = {128{1'b1}};
  localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KEY_X    = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY_Y    = 128'h55AA55AA55AA55AA55AA55AA55AA55AA;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         rst0, rst1, rst2;
  logic [127:0] key_in0, key_in1, key_in2;
  logic         key_load0, key_load1, key_load2;
  logic         start0, start1, start2;
  logic         decrypt0, decrypt1, decrypt2;
  logic         rdy0, rdy1, rdy2;
  logic         vld0, vld1, vld2;
  logic [23:0]  keys0, keys1;
  logic [31:0]  keys2;
  logic [7:0]   idx0, idx1, idx2;
  logic [2:0]   mask0, mask1;
  logic [3:0]   mask2;
  logic         busy0, busy1, busy2;
  logic         done0, done1, done2;

  key_schedule_gen #(.LANES(3), .NUM_KEYS(96)) u_dut0 (
    .CLK(CLK), .RST(rst0), .key_in(key_in0), .key_load(key_load0), .start(start0),
    .decrypt(decrypt0), .out_ready(rdy0), .out_valid(vld0), .out_keys(keys0),
    .out_idx(idx0), .out_lane_mask(mask0), .busy(busy0), .done(done0));

  key_schedule_gen #(.LANES(3), .NUM_KEYS(16)) u_dut1 (
    .CLK(CLK), .RST(rst1), .key_in(key_in1), .key_load(key_load1), .start(start1),
    .decrypt(decrypt1), .out_ready(rdy1), .out_valid(vld1), .out_keys(keys1),
    .out_idx(idx1), .out_lane_mask(mask1), .busy(busy1), .done(done1));

  key_schedule_gen #(.LANES(4), .NUM_KEYS(10)) u_dut2 (
    .CLK(CLK), .RST(rst2), .key_in(key_in2), .key_load(key_load2), .start(start2),
    .decrypt(decrypt2), .out_ready(rdy2), .out_valid(vld2), .out_keys(keys2),
    .out_idx(idx2), .out_lane_mask(mask2), .busy(busy2), .done(done2));

  int n_total  = 0;
  int n_passed = 0;

  beat_t q0[$];
  beat_t q1[$];
  beat_t q2[$];
  bit    pend[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic beat_t qfront(input int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int d);
    case (d)
      0:       q0.delete(0);
      1:       q1.delete(0);
      default: q2.delete(0);
    endcase
  endtask

  task automatic qpush(input int d, input beat_t b);
    case (d)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic qset(input int d, input int i, input beat_t b);
    case (d)
      0:       q0[i] = b;
      1:       q1[i] = b;
      default: q2[i] = b;
    endcase
  endtask

  // Reference K(n): byte position ((n mod 16) - 1) mod 16, counted from the key's MSB.
  function automatic logic [7:0] mk(input logic [127:0] key, input int n);
    int p;
    int b;
    p = n % 16;
    b = (p == 0) ? 15 : p - 1;
    return 8'(n) ^ 8'(key >> (8 * (15 - b)));
  endfunction

  task automatic push_model(input int d, input logic [127:0] key, input bit dec,
                            input int lanes, input int num);
    int nb;
    int base;
    int n;
    beat_t e;
    nb = (num + lanes - 1) / lanes;
    for (int b = 0; b < nb; b++) begin
      base   = dec ? (num - lanes + 1 - b * lanes) : (1 + b * lanes);
      e.idx  = 8'(base);
      e.keys = '0;
      e.mask = '0;
      for (int j = 0; j < lanes; j++) begin
        n = base + j;
        if (n >= 1 && n <= num) begin
          e.keys[8*j +: 8] = mk(key, n);
          e.mask[j]        = 1'b1;
        end
      end
      qpush(d, e);
    end
  endtask

  // Monitor step: compare any presented beat with the queue head; pop on transfer.
  task automatic mon_step(input int d, input logic v, input logic r, input logic dn,
                          input logic [7:0] ix, input logic [31:0] k, input logic [3:0] m);
    beat_t e;
    if (pend[d]) begin
      chk($sformatf("done_after_last_d%0d", d), dn, 1'b1);
      pend[d] = 1'b0;
    end else if (dn) begin
      chk($sformatf("done_spurious_d%0d", d), dn, 1'b0);
    end
    if (v) begin
      if (qsize(d) == 0) begin
        chk($sformatf("beat_unexpected_d%0d", d), 1'b1, 1'b0);
      end else begin
        e = qfront(d);
        chk($sformatf("idx_d%0d", d), ix, e.idx);
        chk($sformatf("keys_d%0d", d), k, e.keys);
        chk($sformatf("mask_d%0d", d), m, e.mask);
        if (r) begin
          qpop(d);
          if (qsize(d) == 0) pend[d] = 1'b1;
        end
      end
    end
  endtask

  always @(negedge CLK) mon_step(0, vld0, rdy0, done0, idx0, {8'h00, keys0}, {1'b0, mask0});
  always @(negedge CLK) mon_step(1, vld1, rdy1, done1, idx1, {8'h00, keys1}, {1'b0, mask1});
  always @(negedge CLK) mon_step(2, vld2, rdy2, done2, idx2, keys2, mask2);

  // Called at posedge+1; drives a one-cycle start/key_load pulse.
  task automatic pulse_start(input int d, input logic dec, input logic ld, input logic [127:0] k);
    case (d)
      0:       begin start0 = 1'b1; decrypt0 = dec; key_load0 = ld; key_in0 = k; end
      1:       begin start1 = 1'b1; decrypt1 = dec; key_load1 = ld; key_in1 = k; end
      default: begin start2 = 1'b1; decrypt2 = dec; key_load2 = ld; key_in2 = k; end
    endcase
    @(posedge CLK); #1;
    start0 = 1'b0; key_load0 = 1'b0;
    start1 = 1'b0; key_load1 = 1'b0;
    start2 = 1'b0; key_load2 = 1'b0;
  endtask

  task automatic wait_done(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      if (qsize(d) == 0 && !pend[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("timeout_d%0d", d), 1'b0, 1'b1);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    key_in0 = '0; key_in1 = '0; key_in2 = '0;
    key_load0 = 1'b0; key_load1 = 1'b0; key_load2 = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    decrypt0 = 1'b0; decrypt1 = 1'b0; decrypt2 = 1'b0;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0; pend[2] = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", vld0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_keys", keys0, 24'h0);
    chk("rst_idx", idx0, 8'h0);
    chk("rst_mask", mask2, 4'h0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    @(posedge CLK); #1;

    // Reset key, descending, with start/key_load pulsed mid-run.
    push_model(0, KEY_ONES, 1'b1, 3, 96);
    qset(0, 0,  beat_t'{8'd94, 32'h009FA0A1, 4'b0111});
    qset(0, 31, beat_t'{8'd1,  32'h00FCFDFE, 4'b0111});
    pulse_start(0, 1'b1, 1'b0, '0);
    chk("busy_run", busy0, 1'b1);
    repeat (8) @(posedge CLK);
    #1;
    pulse_start(0, 1'b0, 1'b1, KEY_Y);
    chk("busy_ignored_start", busy0, 1'b1);
    wait_done(0);
    chk("busy_end", busy0, 1'b0);

    // Load and start together, ascending, with backpressure on beat 2.
    push_model(1, KEY_SEQ, 1'b0, 3, 16);
    qset(1, 0, beat_t'{8'd1,  32'h00010301, 4'b0111});
    qset(1, 5, beat_t'{8'd16, 32'h0000001F, 4'b0001});
    pulse_start(1, 1'b0, 1'b1, KEY_SEQ);
    @(posedge CLK); #1;
    rdy1 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    rdy1 = 1'b1;
    wait_done(1);

    // Four lanes, descending, final index wraps to 0xFF.
    qpush(2, beat_t'{8'd7,   32'hF5F6F7F8, 4'b1111});
    qpush(2, beat_t'{8'd3,   32'hF9FAFBFC, 4'b1111});
    qpush(2, beat_t'{8'hFF,  32'hFDFE0000, 4'b1100});
    pulse_start(2, 1'b1, 1'b0, '0);
    wait_done(2);

    // Reset at beat 5 of a run with a loaded key; the key must revert to all-ones.
    key_in0 = KEY_X; key_load0 = 1'b1;
    @(posedge CLK); #1;
    key_load0 = 1'b0;
    push_model(0, KEY_X, 1'b1, 3, 96);
    pulse_start(0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 100; i++) begin
      if (q0.size() <= 28) break;
      @(posedge CLK); #1;
    end
    chk("beat5_reached", q0.size(), 28);
    rst0 = 1'b1; rdy0 = 1'b0;
    @(posedge CLK); #1;
    rst0 = 1'b0; rdy0 = 1'b1;
    q0.delete();
    chk("abort_valid", vld0, 1'b0);
    chk("abort_busy", busy0, 1'b0);
    chk("abort_done", done0, 1'b0);
    chk("abort_keys", keys0, 24'h0);
    @(posedge CLK); #1;
    push_model(0, KEY_ONES, 1'b1, 3, 96);
    qset(0, 0, beat_t'{8'd94, 32'h009FA0A1, 4'b0111});
    pulse_start(0, 1'b1, 1'b0, '0);
    wait_done(0);
    repeat (2) @(posedge CLK);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
